// File: rtl/stack_arbiter_pkg.sv
// Shared types and encodings for the two-requester stack arbiter.
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DONE   = 2'd1,
        POP_RD = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On contention the requester that was not
// granted last wins; last_grant only moves when the caller commits a grant.
module rr_arb2
    import stack_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant
);

    logic last_q;
    logic last_d;

    // Grant decode and last_grant update
    always_comb begin
        grant = REQ_A;
        if (req_a && req_b) begin
            grant = (last_q == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            grant = REQ_B;
        end
        last_d = advance ? grant : last_q;
    end

    // last_grant register; resets to B so A wins the first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one push/pop stack between requesters A and B. Turns req/ack
// handshakes into single-cycle stack strobes and rejects overflow/underflow
// so the external stack pointer never wraps.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             op_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic             op_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             err,
    output logic [WIDTH-1:0] rsp_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_value_in,
    input  logic [WIDTH-1:0] stk_value_out,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    state_e           state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rsp_q, rsp_d;
    logic             win_q, win_d;

    logic             grant;
    logic             any_req;
    logic             advance;
    logic             win_op;
    logic [WIDTH-1:0] win_data;

    assign any_req  = req_a | req_b;
    assign advance  = (state_q == IDLE) && any_req && !reset;
    assign win_op   = (grant == REQ_B) ? op_b : op_a;
    assign win_data = (grant == REQ_B) ? data_b : data_a;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
        .advance (advance),
        .grant   (grant)
    );

    // Next-state, occupancy tracking and stack strobe decode
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        err_d        = err_q;
        rsp_d        = rsp_q;
        win_d        = win_q;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_value_in = '0;
        case (state_q)
            IDLE: begin
                if (any_req && !reset) begin
                    win_d = grant;
                    if (win_op == OP_PUSH) begin
                        if (!full) begin
                            stk_push     = 1'b1;
                            stk_value_in = win_data;
                            count_d      = count_q + ONE_C;
                            err_d        = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = DONE;
                    end else if (!empty) begin
                        stk_pop = 1'b1;
                        count_d = count_q - ONE_C;
                        err_d   = 1'b0;
                        state_d = POP_RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            // The stack pointer has already stepped down, so its read port
            // now shows the entry that was just popped.
            POP_RD: begin
                rsp_d   = stk_value_out;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            win_q   <= REQ_A;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            win_q   <= win_d;
        end
    end

    assign ack_a    = ((state_q == DONE) || (state_q == RESP)) && (win_q == REQ_A);
    assign ack_b    = ((state_q == DONE) || (state_q == RESP)) && (win_q == REQ_B);
    assign err      = (state_q == DONE) && err_q;
    assign rsp_data = rsp_q;
    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: a queue-based reference stack predicts
// every ack; a monitor compares acks and stack strobes as they appear.
module tb_stack_arbiter;
    import stack_arbiter_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_a, op_a, req_b, op_b;
    logic [W-1:0] data_a, data_b;
    logic         ack_a, ack_b, err;
    logic [W-1:0] rsp_data;
    logic         stk_push, stk_pop;
    logic [W-1:0] stk_value_in, stk_value_out;
    logic [3:0]   count;
    logic         full, empty;

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH(W), .DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .op_a(op_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .data_b(data_b), .ack_b(ack_b),
        .err(err), .rsp_data(rsp_data),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_value_in(stk_value_in), .stk_value_out(stk_value_out),
        .count(count), .full(full), .empty(empty)
    );

    // External stack: pointer = number of entries, read port shows mem[ptr]
    logic [W-1:0] smem [8];
    logic [3:0]   sptr;
    always @(posedge clk) begin
        if (reset) sptr <= '0;
        else if (stk_push) begin
            smem[sptr[2:0]] <= stk_value_in;
            sptr <= sptr + 4'd1;
        end else if (stk_pop) sptr <= sptr - 4'd1;
    end
    assign stk_value_out = smem[sptr[2:0]];

    typedef struct {
        bit           who;
        bit           err;
        bit           pop_ok;
        logic [W-1:0] data;
        int           cnt;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] exp_push[$];
    int           exp_pop_n = 0;
    int           checks = 0;
    int           failures = 0;

    int           mcount = 0;
    logic [W-1:0] mstk[$];
    bit           mlast_b = 1'b1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference stack: LIFO queue with capacity 8
    task automatic model_op(bit who, bit op, logic [W-1:0] d);
        exp_t e;
        e.who = who; e.err = 1'b0; e.pop_ok = 1'b0; e.data = '0;
        if (op == OP_PUSH) begin
            if (mcount == 8) e.err = 1'b1;
            else begin
                mstk.push_back(d);
                mcount++;
                exp_push.push_back(d);
            end
        end else begin
            if (mcount == 0) e.err = 1'b1;
            else begin
                e.data = mstk.pop_back();
                e.pop_ok = 1'b1;
                mcount--;
                exp_pop_n++;
            end
        end
        e.cnt = mcount;
        expq.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stk_push || stk_pop) chk("strobe_excl", {31'd0, stk_push & stk_pop}, 0);
            if (stk_push) begin
                if (exp_push.size() == 0) chk("push_unexpected", {31'd0, stk_push}, 0);
                else chk("push_data", {16'd0, stk_value_in}, {16'd0, exp_push.pop_front()});
            end
            if (stk_pop) begin
                if (exp_pop_n == 0) chk("pop_unexpected", {31'd0, stk_pop}, 0);
                else exp_pop_n--;
            end
            if (ack_a || ack_b) begin
                chk("ack_excl", {31'd0, ack_a & ack_b}, 0);
                if (expq.size() == 0) chk("ack_unexpected", {31'd0, ack_a | ack_b}, 0);
                else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("ack_who", {31'd0, ack_b}, {31'd0, e.who});
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    if (e.pop_ok) chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    chk("count", {28'd0, count}, e.cnt);
                    chk("full", {31'd0, full}, {31'd0, e.cnt == 8});
                    chk("empty", {31'd0, empty}, {31'd0, e.cnt == 0});
                end
            end
        end
    end

    // Entered and left at posedge+1
    task automatic do_reset();
        chk("leftover_before_reset", expq.size() + exp_push.size() + exp_pop_n, 0);
        expq.delete(); exp_push.delete(); exp_pop_n = 0;
        reset = 1'b1;
        req_a = 1'b1; op_a = OP_PUSH; data_a = 16'hDEAD;
        req_b = 1'b0; op_b = OP_PUSH; data_b = '0;
        @(negedge clk);
        chk("strobe_in_reset", {31'd0, stk_push}, 0);
        @(posedge clk); #1;
        req_a = 1'b0;
        @(negedge clk);
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_ack", {30'd0, ack_a, ack_b}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rsp", {16'd0, rsp_data}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mcount = 0; mstk.delete(); mlast_b = 1'b1;
    endtask

    task automatic do_round(bit ua, bit oa, logic [W-1:0] da, bit ub, bit ob, logic [W-1:0] db);
        bit pa, pb, ga, gb;
        int n;
        if (ua && ub) begin
            if (mlast_b) begin
                model_op(1'b0, oa, da); model_op(1'b1, ob, db); mlast_b = 1'b1;
            end else begin
                model_op(1'b1, ob, db); model_op(1'b0, oa, da); mlast_b = 1'b0;
            end
        end else if (ua) begin
            model_op(1'b0, oa, da); mlast_b = 1'b0;
        end else if (ub) begin
            model_op(1'b1, ob, db); mlast_b = 1'b1;
        end
        op_a = oa; data_a = da; req_a = ua;
        op_b = ob; data_b = db; req_b = ub;
        pa = ua; pb = ub; n = 0;
        while ((pa || pb) && n < 40) begin
            @(negedge clk);
            ga = ack_a; gb = ack_b;
            @(posedge clk); #1;
            if (ga) begin pa = 1'b0; req_a = 1'b0; end
            if (gb) begin pb = 1'b0; req_b = 1'b0; end
            n++;
        end
        if (pa || pb) begin
            chk("round_timeout", {30'd0, pa, pb}, 0);
            req_a = 1'b0; req_b = 1'b0;
        end
    endtask

    // Both requesters stream n pushes each, re-raising req one cycle after ack
    task automatic stream_both(int n);
        int ka, kb, ia, ib, t;
        bit who, ga, gb, rea, reb;
        ia = 0; ib = 0;
        who = mlast_b ? 1'b0 : 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            if (who) begin model_op(1'b1, OP_PUSH, 16'hB000 + 16'(ib)); ib++; end
            else     begin model_op(1'b0, OP_PUSH, 16'hA000 + 16'(ia)); ia++; end
            mlast_b = who;
            who = ~who;
        end
        ka = 0; kb = 0; rea = 1'b0; reb = 1'b0; t = 0;
        op_a = OP_PUSH; data_a = 16'hA000; req_a = 1'b1;
        op_b = OP_PUSH; data_b = 16'hB000; req_b = 1'b1;
        while ((ka < n || kb < n) && t < 200) begin
            @(negedge clk);
            ga = ack_a; gb = ack_b;
            @(posedge clk); #1;
            if (rea) begin req_a = 1'b1; data_a = 16'hA000 + 16'(ka); rea = 1'b0; end
            if (reb) begin req_b = 1'b1; data_b = 16'hB000 + 16'(kb); reb = 1'b0; end
            if (ga) begin ka++; req_a = 1'b0; rea = (ka < n); end
            if (gb) begin kb++; req_b = 1'b0; reb = (kb < n); end
            t++;
        end
        if (ka < n || kb < n) chk("stream_timeout", ka + kb, 2 * n);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ua, ub, oa, ob;
        int r;
        reset = 1'b1;
        req_a = 1'b0; op_a = 1'b0; data_a = '0;
        req_b = 1'b0; op_b = 1'b0; data_b = '0;
        @(posedge clk); #1;
        do_reset();

        // Underflow, single push, push-then-pop across requesters
        do_round(1'b1, OP_POP, 16'h0, 1'b0, OP_PUSH, 16'h0);
        do_round(1'b1, OP_PUSH, 16'h1234, 1'b0, OP_PUSH, 16'h0);
        do_round(1'b1, OP_PUSH, 16'hAAAA, 1'b0, OP_PUSH, 16'h0);
        do_round(1'b0, OP_PUSH, 16'h0, 1'b1, OP_POP, 16'h0);
        do_round(1'b0, OP_PUSH, 16'h0, 1'b1, OP_POP, 16'h0);

        // Fill to capacity, overflow, then drain in LIFO order
        for (int i = 0; i < 8; i++) do_round(1'b1, OP_PUSH, 16'(i), 1'b0, OP_PUSH, 16'h0);
        do_round(1'b1, OP_PUSH, 16'hFFFF, 1'b0, OP_PUSH, 16'h0);
        for (int i = 0; i < 8; i++) do_round(1'b0, OP_PUSH, 16'h0, 1'b1, OP_POP, 16'h0);
        do_round(1'b0, OP_PUSH, 16'h0, 1'b1, OP_POP, 16'h0);

        // Fairness under continuous contention, starting from reset
        do_reset();
        stream_both(4);
        do_round(1'b1, OP_PUSH, 16'h7777, 1'b1, OP_PUSH, 16'h8888);

        // Randomized mixed traffic
        do_reset();
        for (int i = 0; i < 120; i++) begin
            r  = $urandom_range(1, 3);
            ua = r[0]; ub = r[1];
            oa = ($urandom_range(0, 99) < ((mcount < 4) ? 65 : 35)) ? OP_PUSH : OP_POP;
            ob = ($urandom_range(0, 99) < ((mcount < 4) ? 65 : 35)) ? OP_PUSH : OP_POP;
            do_round(ua, oa, 16'($urandom), ub, ob, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Reset while a pop is in POP_RD
        do_reset();
        do_round(1'b1, OP_PUSH, 16'h5A5A, 1'b0, OP_PUSH, 16'h0);
        do_round(1'b1, OP_PUSH, 16'h0BAD, 1'b0, OP_PUSH, 16'h0);
        do_round(1'b1, OP_POP, 16'h0, 1'b0, OP_PUSH, 16'h0);
        exp_pop_n++;
        op_a = OP_POP; req_a = 1'b1;
        @(posedge clk); #1;
        chk("pop_rd_state", {30'd0, dut.state_q}, {30'd0, POP_RD});
        reset = 1'b1; req_a = 1'b0;
        @(negedge clk);
        chk("pop_rd_no_ack", {30'd0, ack_a, ack_b}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        chk("midrst_count", {28'd0, count}, 0);
        chk("midrst_rsp", {16'd0, rsp_data}, 0);
        chk("midrst_ack", {30'd0, ack_a, ack_b}, 0);
        chk("midrst_empty", {31'd0, empty}, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        mcount = 0; mstk.delete(); mlast_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_round(1'b1, OP_PUSH, 16'h4321, 1'b1, OP_POP, 16'h0);
        do_round(1'b0, OP_PUSH, 16'h0, 1'b1, OP_POP, 16'h0);

        repeat (3) @(posedge clk);
        chk("leftover_at_end", expq.size() + exp_push.size() + exp_pop_n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Controller and arbiter that shares one 8-entry x 16-bit push/pop stack between two requesters, A and B.
- Converts each requester's req/ack handshake into single-cycle push/pop strobes on the stack.
- Tracks occupancy and rejects overflow/underflow, so the stack pointer can never wrap.
- Sits between client logic and the stack. The stack is reset by the same reset.

Parameters:
- WIDTH, 16, data width of stack entries.
- DEPTH, 8, stack capacity; must equal 2**PTR_W.
- PTR_W, 3, stack pointer width; count is PTR_W+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_a  in  1  requester A has an operation pending; held until ack_a.
- op_a  in  1  0=push, 1=pop; stable while req_a is high.
- data_a  in  WIDTH  push data; stable while req_a is high.
- ack_a  out  1  one-cycle completion pulse to A.
- req_b, op_b, data_b, ack_b  same as the A ports, for requester B.
- err  out  1  valid with ack_x; 1 = operation rejected (push when full, pop when empty).
- rsp_data  out  WIDTH  popped value; valid with ack_x for a successful pop.
- stk_push  out  1  stack push strobe.
- stk_pop  out  1  stack pop strobe.
- stk_value_in  out  WIDTH  data to the stack.
- stk_value_out  in  WIDTH  stack read data (entry at the current top pointer).
- count  out  PTR_W+1  occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset values: state=IDLE, count=0, empty=1, full=0, ack_a=ack_b=0, err=0, rsp_data=0, last_grant=B (so A wins the first contention).
- stk_push, stk_pop and stk_value_in are combinational decodes of state and winner. They are 0 during reset and in every non-IDLE state.
- FSM states: IDLE, DONE, POP_RD, RESP.
- IDLE, no request: remain in IDLE.
- IDLE, arbitration: if only one req is high, it wins. If both are high, the requester that is not last_grant wins (round-robin). last_grant is updated to the winner.
- IDLE, winner push, not full: stk_push=1 and stk_value_in=winner data in this cycle; count+1; go to DONE.
- IDLE, winner pop, not empty: stk_pop=1 in this cycle; count-1; go to POP_RD.
- IDLE, rejected (push when full, or pop when empty): no stack strobe; count unchanged; go to DONE with err=1 latched.
- DONE: ack of the winner=1 for one cycle; err as latched (0 for an accepted push); then go to IDLE.
- POP_RD: stk_value_out now reflects the decremented pointer; capture it into rsp_data; go to RESP.
- RESP: ack of the winner=1, err=0, rsp_data holds the popped value; then go to IDLE.
- Latency from req sampled in IDLE: push or reject ack at +1 cycle; pop ack at +2 cycles.
- Requester handshake: req must drop in the cycle after its ack. A req still high when the FSM returns to IDLE is treated as a new operation.
- The losing requester keeps its req high and is served next. No requester starves: with both continuously requesting, grants alternate A, B, A, ...
- At most one stack strobe per cycle; stk_push and stk_pop are never both 1.
- rsp_data holds its value until the next successful pop.
- Boundaries:
  - count saturates by rejection, never by wrap.
  - Push when count==DEPTH gives err. Pop when count==0 gives err.
  - full and empty are derived combinationally from count.
- Reset mid-operation: the FSM returns to IDLE; any pending ack is cancelled; count=0 (the stack pointer resets together with it).

Decomposition:
- Shared package holds:
  - state enum: IDLE, DONE, POP_RD, RESP;
  - OP_PUSH=0, OP_POP=1;
  - REQ_A=0, REQ_B=1 grant encoding.
- One sub-module is natural: rr_arb2 (2-way round-robin arbiter with a last_grant register, inputs req_a/req_b/advance, output grant).

Test Plan:
- Reset, then A pushes 0x1234 -> stk_push=1 with stk_value_in=0x1234 in the IDLE cycle; ack_a=1, err=0 next cycle; count=1.
- A pushes 0xAAAA, then B pops -> stk_pop=1 in IDLE; ack_b two cycles later with rsp_data=0xAAAA, err=0; count returns to its prior value.
- Pop on empty after reset -> no stk_pop; ack_a at +1 with err=1; count stays 0, empty=1.
- 8 pushes 0x0000..0x0007 -> full=1, count=8. 9th push (0xFFFF) -> err=1, no stk_push. Then 8 pops -> values 0x0007 down to 0x0000, empty=1.
- req_a and req_b both held high for push streams -> grants alternate A, B, A, B; first grant goes to A after reset.
- reset asserted in POP_RD -> no ack is issued; next cycle state=IDLE, count=0, rsp_data=0.
